// File: rtl/wb_arbiter_pkg.sv
// Shared widths and requester identifiers for the write-back arbiter slice.
package wb_arbiter_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NREG = 1 << AW;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_idx_t;

  function automatic req_idx_t other_req(input req_idx_t r);
    return (r == REQ_ALU) ? REQ_MEM : REQ_ALU;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of requester, scoreboard and register-file signals around wb_arbiter.
interface wb_arbiter_if #(
  parameter int XLEN = wb_arbiter_pkg::XLEN,
  parameter int AW   = wb_arbiter_pkg::AW
);
  localparam int NUM_REGS = 1 << AW;

  logic                req0_valid;
  logic [AW-1:0]       req0_addr;
  logic [XLEN-1:0]     req0_data;
  logic                req0_ready;

  logic                req1_valid;
  logic [AW-1:0]       req1_addr;
  logic [XLEN-1:0]     req1_data;
  logic                req1_ready;

  logic                alloc_valid;
  logic [AW-1:0]       alloc_addr;
  logic [AW-1:0]       rs1_addr;
  logic [AW-1:0]       rs2_addr;
  logic                rs1_busy;
  logic                rs2_busy;
  logic [NUM_REGS-1:0] busy_vec;

  logic                RegWrite;
  logic [AW-1:0]       Wt_addr;
  logic [XLEN-1:0]     Wt_data;
  logic                grant_last;

  modport master (
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    output alloc_valid, alloc_addr, rs1_addr, rs2_addr,
    input  rs1_busy, rs2_busy, busy_vec,
    input  RegWrite, Wt_addr, Wt_data, grant_last
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    input  alloc_valid, alloc_addr, rs1_addr, rs2_addr,
    output rs1_busy, rs2_busy, busy_vec,
    output RegWrite, Wt_addr, Wt_data, grant_last
  );

endinterface

// File: rtl/wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational ready, registered priority pointer.
module rr_arb2
  import wb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  output logic [1:0] ready,
  output req_idx_t   grant_last
);

  req_idx_t ptr_q;
  req_idx_t granted;
  logic     handshake;

  always_comb begin
    ready = '0;
    if (valid[0] && (!valid[1] || ptr_q == REQ_ALU)) begin
      ready[0] = 1'b1;
    end else if (valid[1]) begin
      ready[1] = 1'b1;
    end
  end

  assign handshake = |(valid & ready);
  assign granted   = ready[1] ? REQ_MEM : REQ_ALU;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= REQ_ALU;
      grant_last <= REQ_ALU;
    end else if (handshake) begin
      ptr_q      <= other_req(granted);
      grant_last <= granted;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter for the register file: owns the write port and tracks
// registers awaiting a long-latency result.
module wb_arbiter #(
  parameter int XLEN = wb_arbiter_pkg::XLEN,
  parameter int AW   = wb_arbiter_pkg::AW
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);
  import wb_arbiter_pkg::*;

  localparam int NUM_REGS = 1 << AW;

  logic [1:0]          valid;
  logic [1:0]          ready;
  logic                hs0;
  logic                hs1;
  req_idx_t            grant_last_q;

  logic [AW-1:0]       sel_addr;
  logic [XLEN-1:0]     sel_data;

  logic                reg_write_q;
  logic [AW-1:0]       wt_addr_q;
  logic [XLEN-1:0]     wt_data_q;

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  assign valid = {bus.req1_valid, bus.req0_valid};

  rr_arb2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .ready      (ready),
    .grant_last (grant_last_q)
  );

  assign bus.req0_ready = ready[0];
  assign bus.req1_ready = ready[1];
  assign hs0            = valid[0] & ready[0];
  assign hs1            = valid[1] & ready[1];

  always_comb begin
    sel_addr = bus.req0_addr;
    sel_data = bus.req0_data;
    if (hs1) begin
      sel_addr = bus.req1_addr;
      sel_data = bus.req1_data;
    end
  end

  // A grant to x0 still consumes the slot but must never reach the regfile.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_q <= 1'b0;
      wt_addr_q   <= '0;
      wt_data_q   <= '0;
    end else if (hs0 || hs1) begin
      reg_write_q <= (sel_addr != '0);
      wt_addr_q   <= sel_addr;
      wt_data_q   <= sel_data;
    end else begin
      reg_write_q <= 1'b0;
    end
  end

  // Set is applied after clear so a same-edge alloc keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (hs1) begin
      busy_d[bus.req1_addr] = 1'b0;
    end
    if (bus.alloc_valid) begin
      busy_d[bus.alloc_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign bus.rs1_busy   = (bus.rs1_addr != '0) && busy_q[bus.rs1_addr];
  assign bus.rs2_busy   = (bus.rs2_addr != '0) && busy_q[bus.rs2_addr];
  assign bus.busy_vec   = busy_q;
  assign bus.RegWrite   = reg_write_q;
  assign bus.Wt_addr    = wt_addr_q;
  assign bus.Wt_data    = wt_data_q;
  assign bus.grant_last = grant_last_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: directed scenarios then constrained-random traffic.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_arbiter_if bus ();

  wb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit              we;
    bit [AW-1:0]     wa;
    bit [XLEN-1:0]   wd;
    bit              gl;
    bit [NREG-1:0]   bv;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: who wins a tie next, last winner, held write port, pending set.
  int            m_tie;
  int            m_last;
  bit [AW-1:0]   m_wa;
  bit [XLEN-1:0] m_wd;
  bit [NREG-1:0] m_busy;

  // Stimulus for the next edge.
  bit            s_v0, s_v1, s_al;
  bit [AW-1:0]   s_a0, s_a1, s_aa, s_r1, s_r2;
  bit [XLEN-1:0] s_d0, s_d1;
  int            last_g;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tie  = 0;
    m_last = 0;
    m_wa   = '0;
    m_wd   = '0;
    m_busy = '0;
    q.delete();
  endtask

  task automatic idle();
    s_v0 = 0; s_v1 = 0; s_al = 0;
    s_a0 = '0; s_a1 = '0; s_aa = '0; s_r1 = '0; s_r2 = '0;
    s_d0 = '0; s_d1 = '0;
  endtask

  // Called at a negedge: drive, check combinational outputs, predict the edge, wait a cycle.
  task automatic step();
    exp_t e;
    bit   we;
    bus.req0_valid  = s_v0; bus.req0_addr = s_a0; bus.req0_data = s_d0;
    bus.req1_valid  = s_v1; bus.req1_addr = s_a1; bus.req1_data = s_d1;
    bus.alloc_valid = s_al; bus.alloc_addr = s_aa;
    bus.rs1_addr    = s_r1; bus.rs2_addr = s_r2;
    #1;
    if (s_v0 && s_v1)  last_g = m_tie;
    else if (s_v0)     last_g = 0;
    else if (s_v1)     last_g = 1;
    else               last_g = -1;
    chk("req0_ready", bus.req0_ready, last_g == 0);
    chk("req1_ready", bus.req1_ready, last_g == 1);
    chk("rs1_busy", bus.rs1_busy, s_r1 != 0 && m_busy[s_r1]);
    chk("rs2_busy", bus.rs2_busy, s_r2 != 0 && m_busy[s_r2]);
    we = 0;
    if (last_g >= 0) begin
      m_tie  = 1 - last_g;
      m_last = last_g;
      m_wa   = (last_g == 0) ? s_a0 : s_a1;
      m_wd   = (last_g == 0) ? s_d0 : s_d1;
      we     = (m_wa != 0);
    end
    if (last_g == 1) m_busy[s_a1] = 1'b0;
    if (s_al && s_aa != 0) m_busy[s_aa] = 1'b1;
    e.we = we; e.wa = m_wa; e.wd = m_wd; e.gl = m_last[0]; e.bv = m_busy;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    bus.req0_valid = 0; bus.req1_valid = 0; bus.alloc_valid = 0;
    rst = 1'b1;
    #1;
    chk("rst_regwrite", bus.RegWrite, 0);
    chk("rst_busy_vec", bus.busy_vec, 0);
    chk("rst_wt_data", bus.Wt_data, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: each registered output snapshot is matched against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && q.size() > 0) begin
        e = q.pop_front();
        chk("RegWrite", bus.RegWrite, e.we);
        chk("Wt_addr", bus.Wt_addr, e.wa);
        chk("Wt_data", bus.Wt_data, e.wd);
        chk("grant_last", bus.grant_last, e.gl);
        chk("busy_vec", bus.busy_vec, e.bv);
      end
    end
  end

  initial begin
    bit p0, p1;
    idle();
    bus.req0_valid = 0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 0; bus.req1_addr = '0; bus.req1_data = '0;
    bus.alloc_valid = 0; bus.alloc_addr = '0; bus.rs1_addr = '0; bus.rs2_addr = '0;
    model_reset();
    #2;
    chk("init_regwrite", bus.RegWrite, 0);
    chk("init_wt_addr", bus.Wt_addr, 0);
    chk("init_wt_data", bus.Wt_data, 0);
    chk("init_busy_vec", bus.busy_vec, 0);
    chk("init_grant_last", bus.grant_last, 0);
    chk("init_ready", {bus.req0_ready, bus.req1_ready}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Traffic then reset with a write in flight.
    idle(); s_al = 1; s_aa = 6; step();
    idle(); s_v0 = 1; s_a0 = 2; s_d0 = 32'hCAFE0002; step();
    chk("pre_rst_regwrite", bus.RegWrite, 1);
    do_reset();

    idle(); s_v1 = 1; s_a1 = 5; s_d1 = 32'hDEADBEEF; step();
    chk("first_regwrite", bus.RegWrite, 1);
    chk("first_wt_addr", bus.Wt_addr, 5);
    chk("first_wt_data", bus.Wt_data, 32'hDEADBEEF);
    do_reset();

    // Contention from a fresh pointer: 0,1,0,1.
    for (int i = 0; i < 4; i++) begin
      idle(); s_v0 = 1; s_a0 = 3; s_d0 = 32'h11; s_v1 = 1; s_a1 = 4; s_d1 = 32'h22; step();
      chk("contend_grant", bus.grant_last, i % 2);
      chk("contend_regwrite", bus.RegWrite, 1);
    end

    // x0 write consumes the slot and moves the pointer.
    idle(); s_v0 = 1; s_a0 = 0; s_d0 = 32'hFFFFFFFF; step();
    chk("x0_regwrite", bus.RegWrite, 0);
    idle(); s_v0 = 1; s_a0 = 1; s_d0 = 32'h1; s_v1 = 1; s_a1 = 2; s_d1 = 32'h2; step();
    chk("x0_ptr_adv", bus.grant_last, 1);

    // Scoreboard set and clear.
    idle(); s_al = 1; s_aa = 7; step();
    chk("sb_set", bus.busy_vec[7], 1);
    idle(); s_r1 = 7; s_v0 = 1; s_a0 = 7; s_d0 = 32'h77; step();
    chk("sb_rs1_busy", bus.rs1_busy, 1);
    chk("sb_req0_noclear", bus.busy_vec[7], 1);
    idle(); s_r1 = 7; s_v1 = 1; s_a1 = 7; s_d1 = 32'h78; step();
    chk("sb_clear", bus.busy_vec[7], 0);
    chk("sb_rs1_free", bus.rs1_busy, 0);
    idle(); s_al = 1; s_aa = 0; step();
    chk("sb_x0_alloc", bus.busy_vec[0], 0);

    // Set wins over same-edge clear.
    idle(); s_al = 1; s_aa = 9; step();
    idle(); s_al = 1; s_aa = 9; s_v1 = 1; s_a1 = 9; s_d1 = 32'h99; step();
    chk("set_wins", bus.busy_vec[9], 1);

    // Idle hold.
    idle(); s_v0 = 1; s_a0 = 10; s_d0 = 32'h1234; step();
    for (int i = 0; i < 3; i++) begin
      idle(); step();
    end
    chk("hold_regwrite", bus.RegWrite, 0);
    chk("hold_wt_addr", bus.Wt_addr, 10);
    chk("hold_wt_data", bus.Wt_data, 32'h1234);
    chk("hold_grant", bus.grant_last, 0);

    // Random traffic; unaccepted requests hold their payload.
    p0 = 0; p1 = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!p0) begin
        s_v0 = ($urandom_range(0, 99) < 60);
        s_a0 = AW'($urandom_range(0, 15));
        s_d0 = $urandom;
      end
      if (!p1) begin
        s_v1 = ($urandom_range(0, 99) < 60);
        s_a1 = AW'($urandom_range(0, 15));
        s_d1 = $urandom;
      end
      s_al = ($urandom_range(0, 99) < 30);
      s_aa = AW'($urandom_range(0, 15));
      s_r1 = AW'($urandom_range(0, 15));
      s_r2 = AW'($urandom_range(0, 15));
      step();
      p0 = s_v0 && last_g != 0;
      p1 = s_v1 && last_g != 1;
      if (i == 750) begin
        do_reset();
        p0 = 0; p1 = 0;
      end
    end

    idle(); step();
    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
